load_store_unit: RTL and testbench

//  CPU-side initiator for the data-memory interface: takes one load/store per handshake, aligns it to a

---
 rtl/load_store_unit_pkg.sv | 31 +++
 rtl/load_store_unit_align.sv | 44 ++++
 rtl/load_store_unit.sv | 197 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM states, fault codes and RV32I width codes.
// Also provides the func3 legality helper that the FSM uses when it accepts a request.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_MISALIGN = 2'd1;
    localparam logic [1:0] FAULT_FUNC3    = 2'd2;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'd3;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    function automatic logic func3_illegal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return !((f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW));
        return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align: combinational byte-lane steering for stores and extract/extend for loads.
// Latency: zero cycles (pure combinational). Backpressure: none; the caller sequences it.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  off,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  byte_en,
    output logic [31:0] lane_data,
    output logic [31:0] load_data
);

    logic [31:0] masked;
    logic [31:0] shifted;

    always_comb begin
        byte_en = 4'b1111;
        masked  = store_data;
        case (func3[1:0])
            2'd0: begin
                byte_en = 4'b0001 << off;
                masked  = {24'd0, store_data[7:0]};
            end
            2'd1: begin
                byte_en = 4'b0011 << off;
                masked  = {16'd0, store_data[15:0]};
            end
            default: ;
        endcase
        lane_data = masked << {off, 3'b000};

        shifted = load_word >> {off, 3'b000};
        case (func3)
            F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  load_data = {24'd0, shifted[7:0]};
            F3_LHU:  load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// CPU-side data-memory initiator: one load/store per handshake, lane-steered word access, extended load data.
// Latency: accept -> memReq next cycle -> respValid the cycle after memAck (min 2 cycles; faults 1 cycle).
// Backpressure: reqReady only in IDLE; memReq held until memAck or timeout. MISALIGN_TRAP_EN: trap misaligned h/w.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqIsStore,
    input  logic [2:0]            reqFunc3,
    input  logic [ADDR_WIDTH-1:0] reqAddr,
    input  logic [DATA_WIDTH-1:0] reqWriteData,
    output logic                  respValid,
    output logic [DATA_WIDTH-1:0] respReadData,
    output logic                  respFault,
    output logic [1:0]            respFaultCode,
    output logic                  memReq,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic                  memWriteEnable,
    output logic [3:0]            memByteEn,
    output logic [DATA_WIDTH-1:0] memWriteData,
    input  logic                  memAck,
    input  logic [DATA_WIDTH-1:0] memReadData
);

    localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            func3_q, func3_d;
    logic [1:0]            off_q, off_d;
    logic                  is_store_q, is_store_d;
    logic                  mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_we_q, mem_we_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  resp_vld_q, resp_vld_d;
    logic [31:0]           resp_data_q, resp_data_d;
    logic                  resp_fault_q, resp_fault_d;
    logic [1:0]            resp_code_q, resp_code_d;

    logic        misalign;
    logic [1:0]  eff_off;
    logic [2:0]  align_func3;
    logic [1:0]  align_off;
    logic [3:0]  align_be;
    logic [31:0] align_wdata;
    logic [31:0] align_load;

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        misalign = ((reqFunc3[1:0] == 2'd1) && reqAddr[0]) ||
                   ((reqFunc3[1:0] == 2'd2) && (reqAddr[1:0] != 2'd0));
        eff_off  = reqAddr[1:0];
    end
`else
    logic crosses;
    // A word-crossing access is folded onto lane 0 instead of faulting.
    always_comb begin
        crosses  = ((reqFunc3[1:0] == 2'd1) && (reqAddr[1:0] == 2'd3)) ||
                   ((reqFunc3[1:0] == 2'd2) && (reqAddr[1:0] != 2'd0));
        misalign = 1'b0;
        eff_off  = crosses ? 2'd0 : reqAddr[1:0];
    end
`endif

    // One aligner: request fields while idle, captured fields during the memory phase.
    assign align_func3 = (state_q == ST_IDLE) ? reqFunc3 : func3_q;
    assign align_off   = (state_q == ST_IDLE) ? eff_off  : off_q;

    lsu_align u_align (
        .func3      (align_func3),
        .off        (align_off),
        .store_data (reqWriteData),
        .load_word  (memReadData),
        .byte_en    (align_be),
        .lane_data  (align_wdata),
        .load_data  (align_load)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        func3_d      = func3_q;
        off_d        = off_q;
        is_store_d   = is_store_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        resp_vld_d   = 1'b0;
        resp_data_d  = resp_data_q;
        resp_fault_d = resp_fault_q;
        resp_code_d  = resp_code_q;
        case (state_q)
            ST_IDLE: begin
                if (reqValid) begin
                    func3_d    = reqFunc3;
                    off_d      = eff_off;
                    is_store_d = reqIsStore;
                    if (func3_illegal(reqIsStore, reqFunc3) || misalign) begin
                        state_d      = ST_RESP;
                        resp_vld_d   = 1'b1;
                        resp_data_d  = 32'd0;
                        resp_fault_d = 1'b1;
                        resp_code_d  = func3_illegal(reqIsStore, reqFunc3) ? FAULT_FUNC3
                                                                            : FAULT_MISALIGN;
                    end else begin
                        state_d     = ST_REQ;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = {reqAddr[ADDR_WIDTH-1:2], 2'b00};
                        mem_we_d    = reqIsStore;
                        mem_be_d    = align_be;
                        mem_wdata_d = align_wdata;
                    end
                end
            end
            ST_REQ: begin
                // An ack in the final timeout cycle still completes normally.
                if (memAck) begin
                    state_d      = ST_RESP;
                    mem_req_d    = 1'b0;
                    resp_vld_d   = 1'b1;
                    resp_data_d  = is_store_q ? 32'd0 : align_load;
                    resp_fault_d = 1'b0;
                    resp_code_d  = FAULT_NONE;
                end else if (cnt_q == TO_LAST) begin
                    state_d      = ST_RESP;
                    mem_req_d    = 1'b0;
                    resp_vld_d   = 1'b1;
                    resp_data_d  = 32'd0;
                    resp_fault_d = 1'b1;
                    resp_code_d  = FAULT_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            func3_q      <= 3'd0;
            off_q        <= 2'd0;
            is_store_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'd0;
            mem_wdata_q  <= 32'd0;
            resp_vld_q   <= 1'b0;
            resp_data_q  <= 32'd0;
            resp_fault_q <= 1'b0;
            resp_code_q  <= FAULT_NONE;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            func3_q      <= func3_d;
            off_q        <= off_d;
            is_store_q   <= is_store_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_vld_q   <= resp_vld_d;
            resp_data_q  <= resp_data_d;
            resp_fault_q <= resp_fault_d;
            resp_code_q  <= resp_code_d;
        end
    end

    assign reqReady       = (state_q == ST_IDLE);
    assign respValid      = resp_vld_q;
    assign respReadData   = resp_data_q;
    assign respFault      = resp_fault_q;
    assign respFaultCode  = resp_code_q;
    assign memReq         = mem_req_q;
    assign memAddr        = mem_addr_q;
    assign memWriteEnable = mem_we_q;
    assign memByteEn      = mem_be_q;
    assign memWriteData   = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: randomized loads/stores against a byte-level reference model,
// with a memory responder and response monitor that check against scoreboard queues.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        reqIsStore = 1'b0;
    logic [2:0]  reqFunc3 = 3'd0;
    logic [31:0] reqAddr = 32'd0;
    logic [31:0] reqWriteData = 32'd0;
    logic        respValid;
    logic [31:0] respReadData;
    logic        respFault;
    logic [1:0]  respFaultCode;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memWriteEnable;
    logic [3:0]  memByteEn;
    logic [31:0] memWriteData;
    logic        memAck = 1'b0;
    logic [31:0] memReadData = 32'd0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rstn(rstn),
        .reqValid(reqValid), .reqReady(reqReady), .reqIsStore(reqIsStore),
        .reqFunc3(reqFunc3), .reqAddr(reqAddr), .reqWriteData(reqWriteData),
        .respValid(respValid), .respReadData(respReadData), .respFault(respFault),
        .respFaultCode(respFaultCode), .memReq(memReq), .memAddr(memAddr),
        .memWriteEnable(memWriteEnable), .memByteEn(memByteEn), .memWriteData(memWriteData),
        .memAck(memAck), .memReadData(memReadData)
    );

    typedef struct { logic [31:0] data; logic fault; logic [1:0] code; } resp_t;
    typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } memx_t;

    resp_t resp_q[$];
    memx_t memx_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    cur_lat = 0;
    int    last_req_len = 0;
    int    n_memreq = 0;
    int    resp_cnt = 0;
    int    resp_cyc = 0;
    int    last_acc = 0;
    bit    use_fixed = 1'b0;
    logic [31:0] fixed_word = 32'd0;
    resp_t last_r;
    memx_t last_m;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (use_fixed) return fixed_word;
        return ({a[31:2], 2'b00} * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    // Reference model: byte-wise view of each access, computed from the width/offset rules.
    task automatic model_push(input bit is_store, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input int lat);
        int          size, off;
        bit          illegal, mis;
        longint      val;
        logic [31:0] word;
        memx_t       m;
        resp_t       r;
        illegal = is_store ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        size = 1 << f3[1:0];
        off  = int'(addr[1:0]);
        mis  = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis = (size == 2 && addr[0]) || (size == 4 && off != 0);
`else
        if (off + size > 4) off = 0;
`endif
        if (illegal) r = '{32'd0, 1'b1, 2'd2};
        else if (mis) r = '{32'd0, 1'b1, 2'd1};
        else begin
            m.addr = {addr[31:2], 2'b00};
            m.we = is_store;
            m.be = 4'd0;
            m.wdata = 32'd0;
            for (int i = 0; i < size; i++) begin
                m.be[off+i] = 1'b1;
                m.wdata[8*(off+i) +: 8] = wdata[8*i +: 8];
            end
            memx_q.push_back(m);
            if (lat < 0 || lat >= 16) r = '{32'd0, 1'b1, 2'd3};
            else if (is_store) r = '{32'd0, 1'b0, 2'd0};
            else begin
                word = mem_word(addr);
                val = 0;
                for (int i = 0; i < size; i++)
                    val = val | (longint'(word[8*(off+i) +: 8]) << (8*i));
                if (f3 < 3'd4 && size < 4 && val[8*size-1])
                    val = val | ~((64'd1 << (8*size)) - 1);
                r = '{val[31:0], 1'b0, 2'd0};
            end
        end
        resp_q.push_back(r);
    endtask

    task automatic issue(input bit is_store, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int lat);
        int w = 0;
        @(negedge clk);
        while (!reqReady && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!reqReady) begin
            fail_now("issue_wait_reqReady");
            return;
        end
        reqIsStore = is_store;
        reqFunc3 = f3;
        reqAddr = addr;
        reqWriteData = wdata;
        reqValid = 1'b1;
        cur_lat = lat;
        last_acc = cyc;
        model_push(is_store, f3, addr, wdata, lat);
        @(negedge clk);
        reqValid = 1'b0;
    endtask

    task automatic wait_idle();
        int w = 0;
        while (!(resp_q.size() == 0 && reqReady) && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) fail_now("wait_idle_budget");
    endtask

    // Memory responder: checks each new request, acks after cur_lat cycles (negative = never).
    initial begin
        int    req_cnt;
        memx_t m;
        req_cnt = 0;
        forever begin
            @(negedge clk);
            if (memReq) begin
                if (req_cnt == 0) begin
                    n_memreq++;
                    last_m = '{memAddr, memWriteEnable, memByteEn, memWriteData};
                    if (memx_q.size() == 0) fail_now("unexpected_memReq");
                    else begin
                        m = memx_q.pop_front();
                        chk("memAddr", memAddr, m.addr);
                        chk("memWriteEnable", 32'(memWriteEnable), 32'(m.we));
                        chk("memByteEn", 32'(memByteEn), 32'(m.be));
                        if (m.we) chk("memWriteData", memWriteData, m.wdata);
                    end
                end
                if (cur_lat >= 0 && req_cnt == cur_lat) begin
                    memAck = 1'b1;
                    memReadData = mem_word(memAddr);
                end else begin
                    memAck = 1'b0;
                    memReadData = $urandom;
                end
                req_cnt++;
            end else begin
                memAck = 1'b0;
                if (req_cnt > 0) last_req_len = req_cnt;
                req_cnt = 0;
            end
        end
    end

    // Response monitor.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (respValid) begin
                resp_cnt++;
                resp_cyc = cyc;
                last_r = '{respReadData, respFault, respFaultCode};
                if (resp_q.size() == 0) fail_now("unexpected_respValid");
                else begin
                    e = resp_q.pop_front();
                    chk("respReadData", respReadData, e.data);
                    chk("respFault", 32'(respFault), 32'(e.fault));
                    chk("respFaultCode", 32'(respFaultCode), 32'(e.code));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int saved, acc[4];
        repeat (3) @(negedge clk);
        chk("rst_reqReady", 32'(reqReady), 32'd1);
        chk("rst_memReq", 32'(memReq), 32'd0);
        chk("rst_respValid", 32'(respValid), 32'd0);
        chk("rst_respReadData", respReadData, 32'd0);
        chk("rst_respFault", 32'({respFault, respFaultCode}), 32'd0);
        chk("rst_memAddr", memAddr, 32'd0);
        chk("rst_memByteEn", 32'({memWriteEnable, memByteEn}), 32'd0);
        chk("rst_memWriteData", memWriteData, 32'd0);
        rstn = 1'b1;

        use_fixed = 1'b1;
        fixed_word = 32'h80FF7F01;
        issue(0, 3'd0, 32'h103, 32'd0, 0); wait_idle();
        chk("lb_0x103", last_r.data, 32'hFFFFFF80);
        issue(0, 3'd4, 32'h103, 32'd0, 1); wait_idle();
        chk("lbu_0x103", last_r.data, 32'h00000080);
        issue(0, 3'd1, 32'h100, 32'd0, 2); wait_idle();
        chk("lh_0x100", last_r.data, 32'h00007F01);
        use_fixed = 1'b0;

        issue(1, 3'd1, 32'h202, 32'h1234ABCD, 0); wait_idle();
        chk("sh_memAddr", last_m.addr, 32'h200);
        chk("sh_memByteEn", 32'(last_m.be), 32'hC);
        chk("sh_memWriteData", last_m.wdata, 32'hABCD0000);
        chk("sh_memWriteEnable", 32'(last_m.we), 32'd1);

        saved = n_memreq;
        issue(0, 3'd2, 32'h101, 32'd0, 0); wait_idle();
`ifdef MISALIGN_TRAP_EN
        chk("lw_mis_fault", 32'({last_r.fault, last_r.code}), 32'h5);
        chk("lw_mis_no_memReq", n_memreq, saved);
`else
        chk("lw_fold_memAddr", last_m.addr, 32'h100);
        chk("lw_fold_memByteEn", 32'(last_m.be), 32'hF);
`endif

        issue(0, 3'd2, 32'h40, 32'd0, -1); wait_idle();
        chk("timeout_req_len", last_req_len, 16);
        chk("timeout_code", 32'({last_r.fault, last_r.code}), 32'h7);
        issue(0, 3'd2, 32'h40, 32'd0, 15); wait_idle();
        chk("late_ack_req_len", last_req_len, 16);
        chk("late_ack_no_fault", 32'(last_r.fault), 32'd0);

        issue(0, 3'd2, 32'h80, 32'd0, -1);
        repeat (3) @(negedge clk);
        #2 rstn = 1'b0;
        #1 chk("reset_async_memReq", 32'(memReq), 32'd0);
        resp_q.delete();
        saved = resp_cnt;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_no_respValid", resp_cnt, saved);
        issue(1, 3'd0, 32'h7, 32'hAA, 0); wait_idle();
        chk("sb_0x7_be", 32'(last_m.be), 32'h8);
        chk("sb_0x7_data", last_m.wdata, 32'hAA000000);

        saved = n_memreq;
        issue(0, 3'd3, 32'h10, 32'd0, 0); wait_idle();
        chk("ld_f3_3_code", 32'({last_r.fault, last_r.code}), 32'h6);
        issue(1, 3'd4, 32'h10, 32'h55, 0); wait_idle();
        chk("st_f3_4_code", 32'({last_r.fault, last_r.code}), 32'h6);
        chk("illegal_no_memReq", n_memreq, saved);

        for (int i = 0; i < 4; i++) begin
            issue(0, 3'd2, 32'h300 + 32'(4*i), 32'd0, 0);
            acc[i] = last_acc;
        end
        wait_idle();
        for (int i = 1; i < 4; i++) chk("b2b_accept_spacing", acc[i] - acc[i-1], 3);
        chk("min_latency", resp_cyc - acc[3], 2);

        for (int i = 0; i < 80; i++) begin
            int lat;
            lat = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
            issue(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, lat);
        end
        wait_idle();
        chk("memx_q_drained", memx_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
